// File: rtl/soma_display_scan.sv
// Multiplexed 7-segment scan for the adder digits with frame-aligned snapshot commit.
// Optional leading-zero suppression: define SOMA_LEADING_ZERO_BLANK_EN.
module soma_display_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    blank,
    output logic                    ready,
    output logic [3:0]              dec_nibble,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] hold;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    fresh;
    logic                    tick;
    logic                    last;
    logic                    commit;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS-1:0]   lz_mask;

    assign tick   = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last   = (idx == IW'(NUM_DIGITS - 1));
    assign commit = pending && tick && last;
    assign accept = load && ready;
    assign sel    = NUM_DIGITS'(1) << idx;

`ifdef SOMA_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Walk down from the top digit; digit 0 is never suppressed.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (hold[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            fresh <= 1'b1;
        end else begin
            cnt   <= tick ? '0 : cnt + CNT_W'(1);
            fresh <= tick && last;
            if (tick)
                idx <= last ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
        end else if (commit) begin
            hold    <= shadow;
            pending <= 1'b0;
            ready   <= 1'b1;
        end else if (accept) begin
            shadow  <= data_in;
            pending <= 1'b1;
            ready   <= 1'b0;
        end
    end

    // Display outputs lag idx/hold by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_nibble  <= '0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            dec_nibble  <= hold[4*idx +: 4];
            dig_en      <= blank ? '0 : (sel & ~lz_mask);
            frame_start <= fresh && (idx == '0);
        end
    end

endmodule
